if_fetch: RTL and testbench

//  Instruction-fetch front end. Holds the PC, issues in-order fetch requests to

---
 rtl/if_fetch.sv | 207 ++++++++++++++++++++
 tb/tb_if_fetch.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch: instruction-fetch front end.
//
// Holds the PC, issues in-order fetch requests to instruction memory and
// buffers returned words in a small FIFO for decode. A redirect (jump) flushes
// the buffer and drops every response still in flight at that point.
//
// Ports
//   clk_100MHz     in   1       single clock, rising edge
//   arst           in   1       asynchronous reset, active-high
//   hold_ena_i     in   1       decode stall; blocks FIFO pop only
//   jump_ena_i     in   1       redirect request
//   jump_addr_i    in   ADDR_W  redirect target (bits [1:0] ignored)
//   imem_req_o     out  1       fetch request
//   imem_addr_o    out  ADDR_W  fetch address (word aligned)
//   imem_gnt_i     in   1       request accepted when req & gnt
//   imem_rvalid_i  in   1       in-order response valid
//   imem_rdata_i   in   32      response instruction word
//   if_valid_o     out  1       FIFO head valid toward decode
//   if_pc_o        out  ADDR_W  PC of FIFO head
//   if_inst_o      out  32      instruction of FIFO head
// -----------------------------------------------------------------------------
module if_fetch #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2,
    parameter int                MAX_OUT    = 2
) (
    input  logic              clk_100MHz,
    input  logic              arst,
    input  logic              hold_ena_i,
    input  logic              jump_ena_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [31:0]       if_inst_o
);

    localparam int FP_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int QP_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = ADDR_W + 32;

    // State
    logic [ADDR_W-1:0] pc_reg;
    logic [CNT_W-1:0]  out_reg;        // granted but unanswered (incl. discards)
    logic [CNT_W-1:0]  discard_reg;    // oldest in-flight responses to drop
    logic [CNT_W-1:0]  fifo_cnt_reg;
    logic [FP_W-1:0]   fifo_rd_reg;
    logic [FP_W-1:0]   fifo_wr_reg;
    logic [QP_W-1:0]   aq_rd_reg;
    logic [QP_W-1:0]   aq_wr_reg;

    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];   // {pc, inst}
    logic [ADDR_W-1:0] aq_mem   [MAX_OUT];      // addresses of in-flight requests

    // Next-state
    logic [ADDR_W-1:0] pc_next;
    logic [CNT_W-1:0]  out_next;
    logic [CNT_W-1:0]  discard_next;
    logic [CNT_W-1:0]  fifo_cnt_next;

    // Per-cycle events
    logic [CNT_W:0]    inflight_sum;
    logic              credit;
    logic              grant;
    logic              resp;
    logic              resp_drop;
    logic              push;
    logic              pop;
    logic              fifo_nonempty;
    logic [ENT_W-1:0]  head;

    // The two low target bits are architecturally ignored.
    logic              unused_jump_bits;
    assign unused_jump_bits = ^jump_addr_i[1:0];

    function automatic logic [QP_W-1:0] aq_inc(input logic [QP_W-1:0] p);
        if (p == QP_W'(MAX_OUT - 1)) begin
            return '0;
        end
        return p + QP_W'(1);
    endfunction

    // Credit counts discards as outstanding, so a freshly redirected stream
    // can never overrun the FIFO while stale responses are still draining.
    assign inflight_sum  = {1'b0, out_reg} + {1'b0, fifo_cnt_reg};
    assign credit        = (inflight_sum < (CNT_W + 1)'(FIFO_DEPTH)) &&
                           (out_reg < CNT_W'(MAX_OUT));

    assign imem_req_o    = credit & ~jump_ena_i & ~arst;
    assign imem_addr_o   = pc_reg;
    assign grant         = imem_req_o & imem_gnt_i;

    // A response with nothing outstanding is a protocol error; ignore it.
    assign resp          = imem_rvalid_i & (out_reg != '0);
    assign resp_drop     = resp & (discard_reg != '0);
    assign push          = resp & ~resp_drop & ~jump_ena_i;

    assign fifo_nonempty = (fifo_cnt_reg != '0);
    assign if_valid_o    = fifo_nonempty & ~jump_ena_i;
    assign pop           = if_valid_o & ~hold_ena_i;

    assign head          = fifo_mem[fifo_rd_reg];
    assign if_pc_o       = fifo_nonempty ? head[ENT_W-1:32] : '0;
    assign if_inst_o     = fifo_nonempty ? head[31:0]       : '0;

    always_comb begin
        out_next = out_reg;
        if (grant && !resp) begin
            out_next = out_reg + CNT_W'(1);
        end else if (!grant && resp) begin
            out_next = out_reg - CNT_W'(1);
        end
    end

    always_comb begin
        discard_next = discard_reg;
        if (jump_ena_i) begin
            // Everything still in flight after this cycle belongs to the
            // old stream. No grant happens in a jump cycle.
            discard_next = out_next;
        end else if (resp_drop) begin
            discard_next = discard_reg - CNT_W'(1);
        end
    end

    always_comb begin
        fifo_cnt_next = fifo_cnt_reg;
        if (jump_ena_i) begin
            fifo_cnt_next = '0;
        end else if (push && !pop) begin
            fifo_cnt_next = fifo_cnt_reg + CNT_W'(1);
        end else if (pop && !push) begin
            fifo_cnt_next = fifo_cnt_reg - CNT_W'(1);
        end
    end

    always_comb begin
        pc_next = pc_reg;
        if (jump_ena_i) begin
            pc_next = {jump_addr_i[ADDR_W-1:2], 2'b00};
        end else if (grant) begin
            pc_next = pc_reg + ADDR_W'(4);   // wraps modulo 2^ADDR_W
        end
    end

    always_ff @(posedge clk_100MHz or posedge arst) begin
        if (arst) begin
            pc_reg       <= RESET_PC;
            out_reg      <= '0;
            discard_reg  <= '0;
            fifo_cnt_reg <= '0;
            fifo_rd_reg  <= '0;
            fifo_wr_reg  <= '0;
            aq_rd_reg    <= '0;
            aq_wr_reg    <= '0;
        end else begin
            pc_reg       <= pc_next;
            out_reg      <= out_next;
            discard_reg  <= discard_next;
            fifo_cnt_reg <= fifo_cnt_next;

            if (jump_ena_i) begin
                fifo_rd_reg <= '0;
                fifo_wr_reg <= '0;
            end else begin
                if (push) begin
                    fifo_wr_reg <= fifo_wr_reg + FP_W'(1);
                end
                if (pop) begin
                    fifo_rd_reg <= fifo_rd_reg + FP_W'(1);
                end
            end

            // The address queue survives jumps so dropped responses still
            // retire their slot in order.
            if (grant) begin
                aq_wr_reg <= aq_inc(aq_wr_reg);
            end
            if (resp) begin
                aq_rd_reg <= aq_inc(aq_rd_reg);
            end
        end
    end

    // Storage arrays carry no reset; validity is tracked by the counters.
    always_ff @(posedge clk_100MHz) begin
        if (grant) begin
            aq_mem[aq_wr_reg] <= pc_reg;
        end
        if (push) begin
            fifo_mem[fifo_wr_reg] <= {aq_mem[aq_rd_reg], imem_rdata_i};
        end
    end

    rvalid_needs_outstanding: assert property (
        @(posedge clk_100MHz) disable iff (arst)
        !(imem_rvalid_i && (out_reg == '0))
    );

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

    localparam int FIFO_DEPTH = 2;
    localparam int MAX_OUT    = 2;

    logic        clk_100MHz = 1'b0;
    logic        arst = 1'b1;
    logic        hold_ena_i = 1'b0;
    logic        jump_ena_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    if_fetch #(
        .ADDR_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk_100MHz(clk_100MHz), .arst(arst),
        .hold_ena_i(hold_ena_i), .jump_ena_i(jump_ena_i), .jump_addr_i(jump_addr_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain queues
    logic [31:0] m_pc;
    logic [31:0] m_infl[$];     // addresses granted, not yet answered
    logic [63:0] m_fifo[$];     // {pc, inst} waiting for decode
    int          m_discard;

    // Memory environment
    logic [31:0] mq_addr[$];
    int          mq_cyc[$];
    bit          mem_stall;
    int          cyc = 0;

    // Observations for hand checks
    logic [31:0] grants[$];
    int          grant_cyc[$];
    logic [31:0] pops[$];
    int          first_valid_cyc;
    logic        last_req, last_valid;
    logic [31:0] last_addr, last_pc, last_inst;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a ^ 32'hC0DE_1234;
    endfunction

    function automatic logic [31:0] gq(input int i);
        return (grants.size() > i) ? grants[i] : 32'hBAD0_BAD0;
    endfunction

    function automatic logic [31:0] pq(input int i);
        return (pops.size() > i) ? pops[i] : 32'hBAD0_BAD0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_obs();
        grants.delete();
        grant_cyc.delete();
        pops.delete();
        first_valid_cyc = -1;
    endtask

    // One clock cycle: drive memory response, compare outputs, advance model.
    task automatic step();
        logic        credit, e_req, e_valid, dut_fire, fire;
        logic [31:0] e_pc, e_inst, a;
        imem_rvalid_i = !mem_stall && (mq_addr.size() > 0) && (mq_cyc[0] < cyc) && !arst;
        imem_rdata_i  = imem_rvalid_i ? rdata_of(mq_addr[0]) : 32'h0;
        #1;
        credit  = (m_infl.size() + m_fifo.size() < FIFO_DEPTH) && (m_infl.size() < MAX_OUT);
        e_req   = credit && !jump_ena_i && !arst;
        e_valid = (m_fifo.size() != 0) && !jump_ena_i && !arst;
        e_pc    = (m_fifo.size() != 0) ? m_fifo[0][63:32] : 32'h0;
        e_inst  = (m_fifo.size() != 0) ? m_fifo[0][31:0]  : 32'h0;

        check("req",   {31'b0, imem_req_o}, {31'b0, e_req});
        check("addr",  imem_addr_o, m_pc);
        check("valid", {31'b0, if_valid_o}, {31'b0, e_valid});
        if (e_valid || arst) begin
            check("pc",   if_pc_o,   e_pc);
            check("inst", if_inst_o, e_inst);
        end
        $display("cyc=%0d rst=%0b hold=%0b jump=%0b gnt=%0b rv=%0b | req=%0b addr=%h valid=%0b pc=%h inst=%h",
                 cyc, arst, hold_ena_i, jump_ena_i, imem_gnt_i, imem_rvalid_i,
                 imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_inst_o);

        last_req   = imem_req_o;
        last_addr  = imem_addr_o;
        last_valid = if_valid_o;
        last_pc    = if_pc_o;
        last_inst  = if_inst_o;
        dut_fire   = imem_req_o && imem_gnt_i;
        if (dut_fire) begin
            grants.push_back(imem_addr_o);
            grant_cyc.push_back(cyc);
        end
        if (if_valid_o && !hold_ena_i && !jump_ena_i) pops.push_back(if_pc_o);
        if (if_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;

        if (!arst) begin
            fire = e_req && imem_gnt_i;
            if (e_valid && !hold_ena_i) void'(m_fifo.pop_front());
            if (imem_rvalid_i && m_infl.size() > 0) begin
                a = m_infl.pop_front();
                if (m_discard > 0) m_discard--;
                else               m_fifo.push_back({a, imem_rdata_i});
            end
            if (fire) begin
                m_infl.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            if (jump_ena_i) begin
                m_fifo.delete();
                m_pc      = {jump_addr_i[31:2], 2'b00};
                m_discard = m_infl.size();
            end
        end

        if (imem_rvalid_i) begin
            void'(mq_addr.pop_front());
            void'(mq_cyc.pop_front());
        end
        if (dut_fire) begin
            mq_addr.push_back(imem_addr_o);
            mq_cyc.push_back(cyc);
        end
        @(posedge clk_100MHz);
        cyc++;
        @(negedge clk_100MHz);
    endtask

    task automatic do_reset();
        arst        = 1'b1;
        hold_ena_i  = 1'b0;
        jump_ena_i  = 1'b0;
        imem_gnt_i  = 1'b0;
        mem_stall   = 1'b0;
        m_pc        = 32'h0;
        m_infl.delete();
        m_fifo.delete();
        m_discard   = 0;
        mq_addr.delete();
        mq_cyc.delete();
        step();
        check("rst_req",   {31'b0, last_req},   32'h0);
        check("rst_valid", {31'b0, last_valid}, 32'h0);
        check("rst_pc",    last_pc,   32'h0);
        check("rst_inst",  last_inst, 32'h0);
        arst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk_100MHz);

        // 1: streaming fetch after reset
        do_reset();
        clear_obs();
        imem_gnt_i = 1'b1;
        repeat (8) step();
        check("s1_ngrants_ge3", {31'b0, grants.size() >= 3}, 32'h1);
        check("s1_g0", gq(0), 32'h0);
        check("s1_g1", gq(1), 32'h4);
        check("s1_g2", gq(2), 32'h8);
        check("s1_valid_lat", first_valid_cyc - ((grant_cyc.size() > 0) ? grant_cyc[0] : -100), 32'd2);
        check("s1_pop0", pq(0), 32'h0);

        // 2: hold stalls decode, fetching stops on credit
        do_reset();
        clear_obs();
        hold_ena_i = 1'b1;
        imem_gnt_i = 1'b1;
        repeat (5) step();
        check("s2_ngrants", grants.size(), 32'd2);
        check("s2_req_off", {31'b0, last_req}, 32'h0);
        check("s2_head_pc", last_pc, 32'h0);
        hold_ena_i = 1'b0;
        imem_gnt_i = 1'b0;
        pops.delete();
        repeat (2) step();
        check("s2_npops", pops.size(), 32'd2);
        check("s2_pop0", pq(0), 32'h0);
        check("s2_pop1", pq(1), 32'h4);

        // 3: no grant -> request held stable
        do_reset();
        clear_obs();
        for (int i = 0; i < 3; i++) begin
            step();
            check("s3_req",  {31'b0, last_req}, 32'h1);
            check("s3_addr", last_addr, 32'h0);
        end
        imem_gnt_i = 1'b1;
        step();
        check("s3_granted", gq(0), 32'h0);

        // 4: jump with two requests outstanding
        do_reset();
        clear_obs();
        mem_stall  = 1'b1;
        imem_gnt_i = 1'b1;
        repeat (3) step();
        check("s4_ngrants", grants.size(), 32'd2);
        jump_ena_i  = 1'b1;
        jump_addr_i = 32'h103;
        step();
        check("s4_jump_valid", {31'b0, last_valid}, 32'h0);
        check("s4_jump_req",   {31'b0, last_req},   32'h0);
        jump_ena_i = 1'b0;
        mem_stall  = 1'b0;
        clear_obs();
        repeat (8) step();
        check("s4_first_addr", gq(0), 32'h100);
        check("s4_first_pop",  pq(0), 32'h100);

        // 5: jump coincides with response and hold
        do_reset();
        clear_obs();
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        hold_ena_i = 1'b1;
        step();
        imem_gnt_i = 1'b1;
        step();
        jump_ena_i  = 1'b1;
        jump_addr_i = 32'h40;
        step();
        check("s5_jump_valid", {31'b0, last_valid}, 32'h0);
        jump_ena_i = 1'b0;
        hold_ena_i = 1'b0;
        imem_gnt_i = 1'b0;
        step();
        check("s5_empty_after", {31'b0, last_valid}, 32'h0);
        check("s5_no_pops", pops.size(), 32'd0);
        clear_obs();
        imem_gnt_i = 1'b1;
        repeat (4) step();
        check("s5_first_addr", gq(0), 32'h40);

        // 6: PC wrap
        do_reset();
        jump_ena_i  = 1'b1;
        jump_addr_i = 32'hFFFF_FFFE;
        step();
        jump_ena_i = 1'b0;
        imem_gnt_i = 1'b1;
        clear_obs();
        repeat (4) step();
        check("s6_g0", gq(0), 32'hFFFF_FFFC);
        check("s6_g1", gq(1), 32'h0000_0000);

        // 7: reset in the middle of traffic
        clear_obs();
        repeat (3) step();
        do_reset();
        clear_obs();
        imem_gnt_i = 1'b1;
        repeat (3) step();
        check("s7_restart", gq(0), 32'h0);

        // Mixed pattern: hold/gnt/stall interleaving with back-to-back jumps
        for (int i = 0; i < 60; i++) begin
            hold_ena_i  = ((i % 5) == 2);
            imem_gnt_i  = ((i % 3) != 1);
            mem_stall   = ((i % 7) == 3);
            jump_ena_i  = (i == 20) || (i == 21) || (i == 45);
            jump_addr_i = 32'h200 + 32'(i * 8) + 32'(i % 4);
            step();
        end
        hold_ena_i = 1'b0;
        jump_ena_i = 1'b0;
        mem_stall  = 1'b0;
        imem_gnt_i = 1'b0;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
